// File: rtl/ysyx_22040365_ctrl_if.sv
// Instruction-memory fetch channel between the sequencer (master) and imem (slave).
// The request is held until imem answers with a valid word.
interface ysyx_22040365_ctrl_if #(
    parameter int PC_W = 64
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );
endinterface

// File: rtl/ysyx_22040365_ctrl.sv
// Multi-cycle sequencer for the RV64 core: fetch into IR, one execute cycle, gated
// writeback; halts on ebreak, illegal instruction or fetch timeout.
module ysyx_22040365_ctrl #(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h8000_0000),
    parameter int              TIMEOUT  = 16,
    parameter int              CNT_W    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    ysyx_22040365_ctrl_if.master  imem,
    output logic [31:0]           inst,
    input  logic                  illegal,
    output logic                  wb_en,
    output logic [PC_W-1:0]       pc,
    output logic [63:0]           instret,
    output logic                  halt,
    output logic [1:0]            halt_cause
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [31:0]      EBREAK   = 32'h0010_0073;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic             req;
    logic [CNT_W-1:0] wait_cnt;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            inst       <= 32'h0;
            req        <= 1'b0;
            wb_en      <= 1'b0;
            instret    <= 64'h0;
            halt       <= 1'b0;
            halt_cause <= 2'b00;
            wait_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                        req   <= 1'b1;
                    end
                end
                // A valid word on the last permitted wait cycle still wins over the timeout.
                S_FETCH: begin
                    if (imem.imem_valid) begin
                        inst     <= imem.imem_rdata;
                        wait_cnt <= '0;
                        req      <= 1'b0;
                        state    <= S_EXEC;
                    end else if (wait_cnt == CNT_LAST) begin
                        wait_cnt   <= '0;
                        req        <= 1'b0;
                        halt       <= 1'b1;
                        halt_cause <= 2'b11;
                        state      <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (inst == EBREAK) begin
                        halt       <= 1'b1;
                        halt_cause <= 2'b01;
                        state      <= S_HALT;
                    end else if (illegal) begin
                        halt       <= 1'b1;
                        halt_cause <= 2'b10;
                        state      <= S_HALT;
                    end else begin
                        wb_en <= 1'b1;
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    wb_en   <= 1'b0;
                    pc      <= pc + PC_W'(4);
                    instret <= instret + 64'd1;
                    req     <= 1'b1;
                    state   <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040365_ctrl.sv
// Bench for ysyx_22040365_ctrl: directed scenarios plus a randomized instruction stream,
// checked against a transaction-level model of pc / instret / halt behaviour.
module tb_ysyx_22040365_ctrl;

    localparam int          PC_W     = 64;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        illegal = 1'b0;
    logic [31:0] inst;
    logic        wb_en;
    logic [63:0] pc;
    logic [63:0] instret;
    logic        halt;
    logic [1:0]  halt_cause;

    ysyx_22040365_ctrl_if #(.PC_W(PC_W)) imem_if ();

    ysyx_22040365_ctrl #(
        .PC_W    (PC_W),
        .RESET_PC(RESET_PC),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .imem      (imem_if),
        .inst      (inst),
        .illegal   (illegal),
        .wb_en     (wb_en),
        .pc        (pc),
        .instret   (instret),
        .halt      (halt),
        .halt_cause(halt_cause)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] m_pc;
    logic [63:0] m_ret;
    logic [31:0] m_ir;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        #2;
        rst_n               = 1'b0;
        start               = 1'b0;
        imem_if.imem_valid  = 1'b0;
        #1;
        check("rst_req",     64'(imem_if.imem_req), 64'd0);
        check("rst_wb",      64'(wb_en), 64'd0);
        check("rst_pc",      pc, RESET_PC);
        check("rst_addr",    imem_if.imem_addr, RESET_PC);
        check("rst_instret", instret, 64'd0);
        check("rst_halt",    64'(halt), 64'd0);
        check("rst_cause",   64'(halt_cause), 64'd0);
        check("rst_ir",      64'(inst), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_pc  = RESET_PC;
        m_ret = 64'd0;
        m_ir  = 32'h0;
    endtask

    // Called on a negedge while idle; returns on the first FETCH negedge.
    task automatic do_start();
        check("idle_req", 64'(imem_if.imem_req), 64'd0);
        imem_if.imem_valid = 1'($urandom);
        imem_if.imem_rdata = $urandom;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_req",  64'(imem_if.imem_req), 64'd1);
        check("start_addr", imem_if.imem_addr, m_pc);
    endtask

    // One instruction from the current FETCH negedge: valid arrives on wait cycle wt.
    task automatic fetch_exec(input logic [31:0] word, input int wt, input bit ill, input bit stop_wb);
        for (int i = 0; i <= wt; i++) begin
            check("fetch_req",  64'(imem_if.imem_req), 64'd1);
            check("fetch_addr", imem_if.imem_addr, m_pc);
            check("fetch_wb",   64'(wb_en), 64'd0);
            check("fetch_halt", 64'(halt), 64'd0);
            imem_if.imem_valid = (i == wt);
            imem_if.imem_rdata = (i == wt) ? word : $urandom;
            illegal = 1'($urandom);
            start   = 1'($urandom);
            @(negedge clk);
            if (i < wt) check("fetch_ir_hold", 64'(inst), 64'(m_ir));
        end
        m_ir = word;
        check("exec_req", 64'(imem_if.imem_req), 64'd0);
        check("exec_ir",  64'(inst), 64'(word));
        check("exec_wb",  64'(wb_en), 64'd0);
        imem_if.imem_valid = 1'($urandom);
        imem_if.imem_rdata = $urandom;
        illegal = ill;
        start   = 1'($urandom);
        @(negedge clk);
        if (word == EBREAK || ill) begin
            check("halt_flag",    64'(halt), 64'd1);
            check("halt_cause",   64'(halt_cause), (word == EBREAK) ? 64'd1 : 64'd2);
            check("halt_wb",      64'(wb_en), 64'd0);
            check("halt_req",     64'(imem_if.imem_req), 64'd0);
            check("halt_pc",      pc, m_pc);
            check("halt_instret", instret, m_ret);
        end else begin
            check("wb_en",      64'(wb_en), 64'd1);
            check("wb_halt",    64'(halt), 64'd0);
            check("wb_pc",      pc, m_pc);
            check("wb_instret", instret, m_ret);
            if (!stop_wb) begin
                imem_if.imem_valid = 1'($urandom);
                illegal = 1'($urandom);
                start   = 1'($urandom);
                m_pc  = m_pc + 64'd4;
                m_ret = m_ret + 64'd1;
                @(negedge clk);
                check("post_wb_en",   64'(wb_en), 64'd0);
                check("post_pc",      pc, m_pc);
                check("post_instret", instret, m_ret);
            end
        end
        start   = 1'b0;
        illegal = 1'b0;
    endtask

    // imem never answers: HALT with cause 11 after TIMEOUT fetch cycles.
    task automatic fetch_timeout();
        for (int i = 0; i < TIMEOUT; i++) begin
            check("to_req",  64'(imem_if.imem_req), 64'd1);
            check("to_halt", 64'(halt), 64'd0);
            check("to_addr", imem_if.imem_addr, m_pc);
            imem_if.imem_valid = 1'b0;
            imem_if.imem_rdata = $urandom;
            start = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        check("to_halt_flag", 64'(halt), 64'd1);
        check("to_cause",     64'(halt_cause), 64'd3);
        check("to_req_off",   64'(imem_if.imem_req), 64'd0);
        check("to_pc",        pc, m_pc);
    endtask

    task automatic check_frozen(input int n);
        for (int i = 0; i < n; i++) begin
            imem_if.imem_valid = 1'($urandom);
            imem_if.imem_rdata = $urandom;
            illegal = 1'($urandom);
            start   = 1'($urandom);
            @(negedge clk);
            check("frz_halt",    64'(halt), 64'd1);
            check("frz_req",     64'(imem_if.imem_req), 64'd0);
            check("frz_wb",      64'(wb_en), 64'd0);
            check("frz_pc",      pc, m_pc);
            check("frz_instret", instret, m_ret);
            check("frz_ir",      64'(inst), 64'(m_ir));
        end
        start   = 1'b0;
        illegal = 1'b0;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == EBREAK) w = w ^ 32'h1;
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        bit          ill;
        imem_if.imem_valid = 1'b0;
        imem_if.imem_rdata = 32'h0;
        m_pc  = RESET_PC;
        m_ret = 64'd0;
        m_ir  = 32'h0;
        @(negedge clk);

        // addi x1,x0,5 with zero wait
        do_reset();
        do_start();
        fetch_exec(32'h0050_0093, 0, 1'b0, 1'b0);
        check("t1_pc",      pc, 64'h8000_0004);
        check("t1_instret", instret, 64'd1);

        // addi x1,x1,3 then ebreak (illegal also raised: ebreak takes priority)
        fetch_exec(32'h0030_8093, 0, 1'b0, 1'b0);
        fetch_exec(EBREAK, 0, 1'b1, 1'b0);
        check("t2_pc",      pc, 64'h8000_0008);
        check("t2_instret", instret, 64'd2);
        check("t2_cause",   64'(halt_cause), 64'd1);
        check_frozen(4);

        // delayed valid, then valid on the last allowed cycle, then timeout
        do_reset();
        do_start();
        fetch_exec(rand_word(), 4, 1'b0, 1'b0);
        fetch_exec(rand_word(), TIMEOUT - 1, 1'b0, 1'b0);
        fetch_timeout();
        check_frozen(3);

        // illegal instruction
        do_reset();
        do_start();
        fetch_exec(rand_word(), 1, 1'b1, 1'b0);
        check("t5_instret", instret, 64'd0);
        check_frozen(4);

        // reset during fetch wait
        do_reset();
        do_start();
        for (int i = 0; i < 3; i++) begin
            imem_if.imem_valid = 1'b0;
            @(negedge clk);
        end
        do_reset();
        // reset during writeback
        do_start();
        fetch_exec(rand_word(), 0, 1'b0, 1'b1);
        do_reset();
        do_start();
        check("t6_refetch", imem_if.imem_addr, 64'h8000_0000);
        fetch_exec(rand_word(), 2, 1'b0, 1'b0);

        // randomized instruction stream
        for (int k = 0; k < 40; k++) begin
            w   = ($urandom_range(0, 15) == 0) ? EBREAK : rand_word();
            ill = ($urandom_range(0, 7) == 0);
            fetch_exec(w, $urandom_range(0, 5), ill, 1'b0);
            if (w == EBREAK || ill) begin
                check_frozen(2);
                do_reset();
                do_start();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
